// File: rtl/instr_issue_sequencer.sv
// Issue controller for the decode stage: accepts one instruction at a time, classifies it,
// then sequences the ALU strobe, the memory request with timeout, a branch flush or an undefined trap.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for fetch; in_ready=1
// S_DECODE | load instr_type/data_instr_type, choose path from cond_pass
// S_EXEC   | one-cycle ALU strobe
// S_MEM    | mem_req held until mem_ack or timeout
// S_BRANCH | one-cycle flush, branch_link from IR[24]
// S_UNDEF  | one-cycle undefined-instruction trap
// S_ERR    | one-cycle mem_err, no retire
// S_DONE   | one-cycle retire strobe, retire_count advances
module instr_issue_sequencer #(
   parameter int CNT_W       = 16,
   parameter int TO_W        = 8,
   parameter int MEM_TIMEOUT = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic             cond_pass,
   output logic [2:0]       instr_type,
   output logic [3:0]       data_instr_type,
   output logic             alu_en,
   output logic             mem_req,
   output logic             mem_we,
   input  logic             mem_ack,
   output logic             flush,
   output logic             branch_link,
   output logic             undef_trap,
   output logic             mem_err,
   output logic             retire,
   output logic             squashed,
   output logic [CNT_W-1:0] retire_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_EXEC, S_MEM, S_BRANCH, S_UNDEF, S_ERR, S_DONE
   } state_t;

   state_t           state_q;
   logic [31:0]      ir_q;
   logic [2:0]       instr_type_q;
   logic [3:0]       data_instr_type_q;
   logic [TO_W-1:0]  cnt_q;
   logic [CNT_W-1:0] retire_count_q;
   logic             squash_q;
   logic             alu_en_q, mem_req_q, mem_we_q, flush_q, branch_link_q;
   logic             undef_trap_q, mem_err_q, retire_q, squashed_q;

   logic [2:0]       instr_type_d;
   logic [3:0]       data_instr_type_d;
   logic             ir_unused;

   always_comb begin
      instr_type_d = 3'b000;
      case (ir_q[27:26])
         2'b00:   instr_type_d = 3'b001;
         2'b01:   instr_type_d = 3'b010;
         2'b10:   instr_type_d = 3'b011;
         default: instr_type_d = 3'b000;
      endcase
      data_instr_type_d = 4'b0000;
      if (ir_q[25])
         data_instr_type_d = 4'b0001;
      else if (!ir_q[4])
         data_instr_type_d = 4'b0010;
      else if (!ir_q[7])
         data_instr_type_d = 4'b0011;
   end

   // Condition field and register specifiers are resolved elsewhere in the pipeline.
   assign ir_unused = ^{ir_q[31:28], ir_q[23:21], ir_q[19:8], ir_q[6:5], ir_q[3:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= S_IDLE;
         ir_q              <= '0;
         instr_type_q      <= '0;
         data_instr_type_q <= '0;
         cnt_q             <= '0;
         retire_count_q    <= '0;
         squash_q          <= 1'b0;
         alu_en_q          <= 1'b0;
         mem_req_q         <= 1'b0;
         mem_we_q          <= 1'b0;
         flush_q           <= 1'b0;
         branch_link_q     <= 1'b0;
         undef_trap_q      <= 1'b0;
         mem_err_q         <= 1'b0;
         retire_q          <= 1'b0;
         squashed_q        <= 1'b0;
      end else begin
         // Strobes are one-cycle unless re-armed by the transition below.
         alu_en_q      <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         flush_q       <= 1'b0;
         branch_link_q <= 1'b0;
         undef_trap_q  <= 1'b0;
         mem_err_q     <= 1'b0;
         retire_q      <= 1'b0;
         squashed_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  ir_q    <= in_instr;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               instr_type_q      <= instr_type_d;
               data_instr_type_q <= data_instr_type_d;
               cnt_q             <= '0;
               squash_q          <= 1'b0;
               if (ir_q[27:26] != 2'b11 && !cond_pass) begin
                  squash_q   <= 1'b1;
                  retire_q   <= 1'b1;
                  squashed_q <= 1'b1;
                  state_q    <= S_DONE;
               end else begin
                  case (ir_q[27:26])
                     2'b00: begin
                        alu_en_q <= 1'b1;
                        state_q  <= S_EXEC;
                     end
                     2'b01: begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= ~ir_q[20];
                        state_q   <= S_MEM;
                     end
                     2'b10: begin
                        flush_q       <= 1'b1;
                        branch_link_q <= ir_q[24];
                        state_q       <= S_BRANCH;
                     end
                     default: begin
                        undef_trap_q <= 1'b1;
                        state_q      <= S_UNDEF;
                     end
                  endcase
               end
            end
            S_EXEC, S_BRANCH, S_UNDEF: begin
               retire_q   <= 1'b1;
               squashed_q <= squash_q;
               state_q    <= S_DONE;
            end
            S_MEM: begin
               if (mem_ack) begin
                  retire_q   <= 1'b1;
                  squashed_q <= squash_q;
                  state_q    <= S_DONE;
               end else if (cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
                  mem_err_q <= 1'b1;
                  state_q   <= S_ERR;
               end else begin
                  cnt_q     <= cnt_q + 1'b1;
                  mem_req_q <= 1'b1;
                  mem_we_q  <= ~ir_q[20];
               end
            end
            S_ERR: begin
               state_q <= S_IDLE;
            end
            S_DONE: begin
               retire_count_q <= retire_count_q + 1'b1;
               state_q        <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready        = (state_q == S_IDLE);
   assign instr_type      = instr_type_q;
   assign data_instr_type = data_instr_type_q;
   assign alu_en          = alu_en_q;
   assign mem_req         = mem_req_q;
   assign mem_we          = mem_we_q;
   assign flush           = flush_q;
   assign branch_link     = branch_link_q;
   assign undef_trap      = undef_trap_q;
   assign mem_err         = mem_err_q;
   assign retire          = retire_q;
   assign squashed        = squashed_q;
   assign retire_count    = retire_count_q;

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Scoreboard bench for instr_issue_sequencer: per-instruction timing checked by the driver,
// retire/err content checked by a monitor popping expected entries.
module tb_instr_issue_sequencer;

   localparam int CNT_W = 4;
   localparam int TO_W  = 8;
   localparam int TO    = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_instr = '0;
   logic             cond_pass = 1'b0;
   logic [2:0]       instr_type;
   logic [3:0]       data_instr_type;
   logic             alu_en, mem_req, mem_we, mem_ack, flush, branch_link;
   logic             undef_trap, mem_err, retire, squashed;
   logic [CNT_W-1:0] retire_count;

   typedef struct {
      bit         is_err;
      logic [2:0] itype;
      logic [3:0] dtype;
      bit         sq;
   } exp_t;

   exp_t             sb[$];
   exp_t             mon_e;
   logic [CNT_W-1:0] model_cnt = '0;
   int               n_tests = 0;
   int               n_fail  = 0;

   instr_issue_sequencer #(.CNT_W(CNT_W), .TO_W(TO_W), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .cond_pass(cond_pass), .instr_type(instr_type), .data_instr_type(data_instr_type),
      .alu_en(alu_en), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .flush(flush),
      .branch_link(branch_link), .undef_trap(undef_trap), .mem_err(mem_err), .retire(retire),
      .squashed(squashed), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (retire || mem_err)) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_kind", 32'(mem_err), 32'(mon_e.is_err));
            chk("sb_count", 32'(retire_count), 32'(model_cnt));
            if (retire) begin
               chk("sb_itype", 32'(instr_type), 32'(mon_e.itype));
               chk("sb_dtype", 32'(data_instr_type), 32'(mon_e.dtype));
               chk("sb_squash", 32'(squashed), 32'(mon_e.sq));
               model_cnt = model_cnt + 1'b1;
            end
         end
      end
   end

   // ack_after: MEM cycle (1-based) in which mem_ack is raised; 0 = never.
   task automatic run(input logic [31:0] instr, input bit cond, input int ack_after);
      logic [1:0] cls;
      exp_t       e;
      bit         sq;
      int         exp_end, exp_alu, exp_flush, exp_trap, exp_mem;
      int         end_off, alu_at, flush_at, trap_at, memcyc;
      bit         we_bad, link_v;
      cls = instr[27:26];
      sq  = (cls != 2'b11) && !cond;
      e.itype  = (cls == 2'b00) ? 3'b001 : (cls == 2'b01) ? 3'b010 : (cls == 2'b10) ? 3'b011 : 3'b000;
      e.dtype  = instr[25] ? 4'b0001 : !instr[4] ? 4'b0010 : !instr[7] ? 4'b0011 : 4'b0000;
      e.sq     = sq;
      e.is_err = !sq && cls == 2'b01 && ack_after == 0;
      exp_alu   = (!sq && cls == 2'b00) ? 2 : 0;
      exp_flush = (!sq && cls == 2'b10) ? 2 : 0;
      exp_trap  = (cls == 2'b11) ? 2 : 0;
      exp_mem   = (!sq && cls == 2'b01) ? ((ack_after > 0) ? ack_after : TO) : 0;
      exp_end   = sq ? 2 : (cls == 2'b01) ? exp_mem + 2 : 3;
      sb.push_back(e);
      @(negedge clk);
      chk("accept_ready", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      in_instr  = instr;
      cond_pass = cond;
      end_off = 0; alu_at = 0; flush_at = 0; trap_at = 0; memcyc = 0;
      we_bad = 1'b0; link_v = 1'b0;
      for (int off = 1; off <= 40 && end_off == 0; off++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (off == 1) chk("decode_busy", 32'(in_ready), 32'd0);
         if (alu_en && alu_at == 0) alu_at = off;
         if (flush && flush_at == 0) begin
            flush_at = off;
            link_v   = branch_link;
         end
         if (undef_trap && trap_at == 0) trap_at = off;
         if (mem_req) begin
            memcyc++;
            if (mem_we !== ~instr[20]) we_bad = 1'b1;
         end else if (mem_we) begin
            we_bad = 1'b1;
         end
         mem_ack = mem_req && ack_after > 0 && memcyc == ack_after;
         if (retire || mem_err) end_off = off;
      end
      mem_ack = 1'b0;
      chk("end_cycle", 32'(end_off), 32'(exp_end));
      chk("alu_cycle", 32'(alu_at), 32'(exp_alu));
      chk("flush_cycle", 32'(flush_at), 32'(exp_flush));
      chk("trap_cycle", 32'(trap_at), 32'(exp_trap));
      chk("mem_req_cycles", 32'(memcyc), 32'(exp_mem));
      chk("mem_we", 32'(we_bad), 32'd0);
      if (exp_flush != 0) chk("branch_link", 32'(link_v), 32'(instr[24]));
      @(negedge clk);
      chk("ready_again", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_itype", 32'(instr_type), 32'd0);
      chk("rst_dtype", 32'(data_instr_type), 32'd0);
      chk("rst_count", 32'(retire_count), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      rst = 1'b0;

      run(32'hE3A01005, 1'b1, 0);   // DP immediate
      run(32'hE5901000, 1'b1, 3);   // LDR, ack in 3rd MEM cycle
      run(32'hE5801000, 1'b1, 0);   // STR, timeout
      run(32'hE5801000, 1'b1, TO);  // ack coincides with timeout cycle
      run(32'hEB000010, 1'b1, 0);   // BL
      run(32'hEA000010, 1'b1, 0);   // B (no link)
      run(32'hEC000000, 1'b0, 0);   // class 11 traps regardless of cond
      run(32'h00810002, 1'b0, 0);   // DP reg, squashed
      run(32'hE0810012, 1'b1, 0);   // DP reg-shift-reg
      run(32'hE0810092, 1'b1, 0);   // multiply-class encoding

      while (model_cnt != '1) run(32'h00810002, 1'b0, 0);
      chk("cnt_max", 32'(retire_count), 32'(2**CNT_W - 1));
      run(32'h00810002, 1'b0, 0);
      chk("cnt_wrap", 32'(retire_count), 32'd0);
      run(32'hE3A01005, 1'b1, 0);

      @(negedge clk);
      in_valid  = 1'b1;
      in_instr  = 32'hE5801000;
      cond_pass = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mid_ready", 32'(in_ready), 32'd1);
      chk("rst_mid_count", 32'(retire_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      model_cnt = '0;
      run(32'hEB000010, 1'b1, 0);

      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
